// File: rtl/multi_cycle_ctrl_if.sv
// Bus between the multi-cycle sequencer and its datapath: fetch/decode inputs,
// register-file and data-memory handshakes, and sequencer status outputs.
interface multi_cycle_ctrl_if #(
    parameter int DATA_LEN     = 32,
    parameter int REG_ADDR_LEN = 5
);
    // Datapath -> sequencer
    logic                    run;
    logic                    imem_ready;
    logic [1:0]              instr_class;
    logic                    instr_wb_en;
    logic [REG_ADDR_LEN-1:0] instr_rd;
    logic [DATA_LEN-1:0]     rdata1;
    logic [DATA_LEN-1:0]     rdata2;
    logic [DATA_LEN-1:0]     alu_result;
    logic                    dmem_ready;
    logic [DATA_LEN-1:0]     dmem_rdata;

    // Sequencer -> datapath
    logic                    state_regfile_read;
    logic                    state_regfile_write;
    logic                    we;
    logic [REG_ADDR_LEN-1:0] waddr;
    logic [DATA_LEN-1:0]     wdata;
    logic [DATA_LEN-1:0]     opa;
    logic [DATA_LEN-1:0]     opb;
    logic                    ir_we;
    logic                    pc_we;
    logic                    dmem_req;
    logic                    dmem_wr;
    logic [2:0]              state;
    logic                    instr_done;
    logic                    timeout_err;

    modport master (
        input  run, imem_ready, instr_class, instr_wb_en, instr_rd,
               rdata1, rdata2, alu_result, dmem_ready, dmem_rdata,
        output state_regfile_read, state_regfile_write, we, waddr, wdata,
               opa, opb, ir_we, pc_we, dmem_req, dmem_wr, state,
               instr_done, timeout_err
    );

    modport slave (
        output run, imem_ready, instr_class, instr_wb_en, instr_rd,
               rdata1, rdata2, alu_result, dmem_ready, dmem_rdata,
        input  state_regfile_read, state_regfile_write, we, waddr, wdata,
               opa, opb, ir_we, pc_we, dmem_req, dmem_wr, state,
               instr_done, timeout_err
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle instruction sequencer: IF -> ID -> EX -> (MEM) -> (WB), owns all
// register-file traffic, latches operands/results and guards waits with a timeout.
module multi_cycle_ctrl #(
    parameter int DATA_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    multi_cycle_ctrl_if.master bus
);

    localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IF      = 3'd1,
        S_ID      = 3'd2,
        S_EX      = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_ERR     = 3'd6,
        S_ILLEGAL = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'b00,
        CLS_LOAD   = 2'b01,
        CLS_STORE  = 2'b10,
        CLS_BRANCH = 2'b11
    } cls_e;

    state_e                  state_q, state_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic [WAIT_W-1:0]       wait_inc;
    logic [DATA_LEN-1:0]     opa_q, opa_d;
    logic [DATA_LEN-1:0]     opb_q, opb_d;
    logic [DATA_LEN-1:0]     alu_q, alu_d;
    logic [DATA_LEN-1:0]     mem_q, mem_d;
    logic [REG_ADDR_LEN-1:0] waddr_q, waddr_d;
    cls_e                    cls_q, cls_d;
    logic                    wb_q, wb_d;
    logic                    done_q, done_d;
    logic                    terr_q, terr_d;

    assign wait_inc = wait_q + 1'b1;

    // Datapath latches are reset too, so a reset mid-instruction leaves no stale operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            alu_q   <= '0;
            mem_q   <= '0;
            waddr_q <= '0;
            cls_q   <= CLS_ALU;
            wb_q    <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            wait_q  <= wait_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            alu_q   <= alu_d;
            mem_q   <= mem_d;
            waddr_q <= waddr_d;
            cls_q   <= cls_d;
            wb_q    <= wb_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        // NOTE: every _d takes its hold value first so no branch of the case can infer a latch.
        state_d = state_q;
        wait_d  = '0;
        opa_d   = opa_q;
        opb_d   = opb_q;
        alu_d   = alu_q;
        mem_d   = mem_q;
        waddr_d = waddr_q;
        cls_d   = cls_q;
        wb_d    = wb_q;
        done_d  = 1'b0;
        terr_d  = terr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_IF;
            end

            S_IF: begin
                if (bus.imem_ready) begin
                    state_d = S_ID;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        state_d = S_ERR;
                        terr_d  = 1'b1;
                    end
                end
            end

            S_ID: begin
                opa_d   = bus.rdata1;
                opb_d   = bus.rdata2;
                waddr_d = bus.instr_rd;
                cls_d   = cls_e'(bus.instr_class);
                wb_d    = bus.instr_wb_en;
                state_d = S_EX;
            end

            S_EX: begin
                alu_d = bus.alu_result;
                if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
                    state_d = S_MEM;
                end else if (wb_q) begin
                    state_d = S_WB;
                end else begin
                    done_d  = 1'b1;
                    state_d = bus.run ? S_IF : S_IDLE;
                end
            end

            S_MEM: begin
                if (bus.dmem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        done_d  = 1'b1;
                        state_d = bus.run ? S_IF : S_IDLE;
                    end else begin
                        mem_d   = bus.dmem_rdata;
                        state_d = S_WB;
                    end
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WAIT_LIMIT) begin
                        state_d = S_ERR;
                        terr_d  = 1'b1;
                    end
                end
            end

            S_WB: begin
                done_d  = 1'b1;
                state_d = bus.run ? S_IF : S_IDLE;
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes decode the registered state; the fetch strobes additionally qualify
    // on imem_ready so IR/PC load in the very cycle the instruction word is valid.
    assign bus.state_regfile_read  = (state_q == S_ID);
    assign bus.state_regfile_write = (state_q == S_WB);
    assign bus.ir_we               = (state_q == S_IF) && bus.imem_ready;
    assign bus.pc_we               = (state_q == S_IF) && bus.imem_ready;
    assign bus.dmem_req            = (state_q == S_MEM);
    assign bus.dmem_wr             = (state_q == S_MEM) && (cls_q == CLS_STORE);

    // Writes to x0 are suppressed; write data comes only from latched results.
    assign bus.we    = (state_q == S_WB) && wb_q && (waddr_q != '0);
    assign bus.wdata = (state_q != S_WB) ? '0 : ((cls_q == CLS_LOAD) ? mem_q : alu_q);
    assign bus.waddr = waddr_q;
    assign bus.opa   = opa_q;
    assign bus.opb   = opb_q;

    assign bus.state       = state_q;
    assign bus.instr_done  = done_q;
    assign bus.timeout_err = terr_q;

    // Retire pulses can never occur back to back: every instruction spends at least IF..EX.
    a_done_single: assert property (@(posedge clk) disable iff (!rst)
        done_q |=> !done_q);

    a_err_sticky: assert property (@(posedge clk) disable iff (!rst)
        state_q == S_ERR |=> state_q == S_ERR);

    a_we_only_in_wb: assert property (@(posedge clk) disable iff (!rst)
        bus.we |-> state_q == S_WB);

    a_rf_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(bus.state_regfile_read && bus.state_regfile_write));

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: state traces, regfile writes, memory
// handshakes, operand latching, wait timeouts and asynchronous reset.
module tb_multi_cycle_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl #(
        .DATA_LEN     (32),
        .REG_ADDR_LEN (5),
        .WAIT_TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        bus.run = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.run = 1'b1;
        bus.imem_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset state got %0d want 0", bus.state); end
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset we got %b want 0", bus.we); end
        checks++; if (bus.ir_we !== 1'b0) begin errors++; $display("FAIL reset ir_we got %b want 0", bus.ir_we); end
        checks++; if (bus.opa !== 32'h0 || bus.opb !== 32'h0) begin errors++; $display("FAIL reset opa/opb got %h/%h want 0/0", bus.opa, bus.opb); end
        checks++; if (bus.waddr !== 5'd0 || bus.wdata !== 32'h0) begin errors++; $display("FAIL reset waddr/wdata got %0d/%h want 0/0", bus.waddr, bus.wdata); end
        checks++; if (bus.timeout_err !== 1'b0 || bus.instr_done !== 1'b0) begin errors++; $display("FAIL reset err/done got %b/%b want 0/0", bus.timeout_err, bus.instr_done); end
        checks++; if (bus.dmem_req !== 1'b0 || bus.state_regfile_read !== 1'b0) begin errors++; $display("FAIL reset req/rd got %b/%b want 0/0", bus.dmem_req, bus.state_regfile_read); end
        rst = 1'b1;
        bus.run = 1'b0;
    endtask

    // ALU with write, then a BRANCH without write issued with run dropped.
    task automatic test_alu_branch();
        int exp_state [9] = '{1, 2, 3, 5, 1, 2, 3, 0, 0};
        int exp_done  [9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
        int exp_irwe  [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
        bus.run = 1'b1; bus.imem_ready = 1'b1; bus.instr_class = 2'b00;
        bus.instr_rd = 5'd5; bus.instr_wb_en = 1'b1; bus.alu_result = 32'h1234;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++; if (bus.state !== 3'(exp_state[i])) begin errors++; $display("FAIL alu state[%0d] got %0d want %0d", i, bus.state, exp_state[i]); end
            checks++; if (bus.instr_done !== 1'(exp_done[i])) begin errors++; $display("FAIL alu done[%0d] got %b want %0d", i, bus.instr_done, exp_done[i]); end
            checks++; if (bus.ir_we !== 1'(exp_irwe[i])) begin errors++; $display("FAIL alu ir_we[%0d] got %b want %0d", i, bus.ir_we, exp_irwe[i]); end
            checks++; if (bus.we !== (i == 3)) begin errors++; $display("FAIL alu we[%0d] got %b want %b", i, bus.we, (i == 3)); end
            checks++; if (bus.state_regfile_read !== (i == 1 || i == 5)) begin errors++; $display("FAIL alu rf_read[%0d] got %b", i, bus.state_regfile_read); end
            if (i == 3) begin
                checks++; if (bus.waddr !== 5'd5) begin errors++; $display("FAIL alu waddr got %0d want 5", bus.waddr); end
                checks++; if (bus.wdata !== 32'h1234) begin errors++; $display("FAIL alu wdata got %h want 00001234", bus.wdata); end
            end
            if (i == 4) begin
                bus.run = 1'b0; bus.instr_class = 2'b11; bus.instr_wb_en = 1'b0;
            end
        end
    endtask

    // LOAD with three MEM cycles; operands change after ID and must not follow.
    task automatic test_load_operands();
        int exp_state [8] = '{1, 2, 3, 4, 4, 4, 5, 0};
        bus.run = 1'b1; bus.imem_ready = 1'b1; bus.instr_class = 2'b01;
        bus.instr_rd = 5'd7; bus.instr_wb_en = 1'b1; bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'hDEADBEEF; bus.rdata1 = 32'hA; bus.rdata2 = 32'hB;
        bus.alu_result = 32'h100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (bus.state !== 3'(exp_state[i])) begin errors++; $display("FAIL load state[%0d] got %0d want %0d", i, bus.state, exp_state[i]); end
            checks++; if (bus.dmem_req !== (i >= 3 && i <= 5) || bus.dmem_wr !== 1'b0) begin errors++; $display("FAIL load req/wr[%0d] got %b/%b", i, bus.dmem_req, bus.dmem_wr); end
            checks++; if (bus.instr_done !== (i == 7)) begin errors++; $display("FAIL load done[%0d] got %b", i, bus.instr_done); end
            if (i >= 2 && i <= 6) begin
                checks++; if (bus.opa !== 32'hA || bus.opb !== 32'hB) begin errors++; $display("FAIL load operands[%0d] got %h/%h want a/b", i, bus.opa, bus.opb); end
            end
            if (i == 6) begin
                checks++; if (bus.we !== 1'b1 || bus.state_regfile_write !== 1'b1) begin errors++; $display("FAIL load we/rf_write got %b/%b want 1/1", bus.we, bus.state_regfile_write); end
                checks++; if (bus.waddr !== 5'd7) begin errors++; $display("FAIL load waddr got %0d want 7", bus.waddr); end
                checks++; if (bus.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load wdata got %h want deadbeef", bus.wdata); end
            end
            if (i == 1) bus.run = 1'b0;
            if (i == 2) begin bus.rdata1 = 32'hFF; bus.rdata2 = 32'hFF; end
            if (i == 5) bus.dmem_ready = 1'b1;
            if (i == 6) bus.dmem_ready = 1'b0;
        end
    endtask

    task automatic test_store();
        int exp_state [6] = '{1, 2, 3, 4, 0, 0};
        bus.run = 1'b1; bus.imem_ready = 1'b1; bus.instr_class = 2'b10;
        bus.instr_rd = 5'd3; bus.instr_wb_en = 1'b1; bus.dmem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (bus.state !== 3'(exp_state[i])) begin errors++; $display("FAIL store state[%0d] got %0d want %0d", i, bus.state, exp_state[i]); end
            checks++; if (bus.dmem_wr !== (i == 3) || bus.dmem_req !== (i == 3)) begin errors++; $display("FAIL store wr/req[%0d] got %b/%b", i, bus.dmem_wr, bus.dmem_req); end
            checks++; if (bus.we !== 1'b0 || bus.state_regfile_write !== 1'b0) begin errors++; $display("FAIL store we/rf_write[%0d] got %b/%b want 0/0", i, bus.we, bus.state_regfile_write); end
            checks++; if (bus.instr_done !== (i == 4)) begin errors++; $display("FAIL store done[%0d] got %b", i, bus.instr_done); end
            if (i == 1) bus.run = 1'b0;
        end
        bus.dmem_ready = 1'b0;
    endtask

    task automatic test_rd_zero();
        int exp_state [5] = '{1, 2, 3, 5, 0};
        bus.run = 1'b1; bus.imem_ready = 1'b1; bus.instr_class = 2'b00;
        bus.instr_rd = 5'd0; bus.instr_wb_en = 1'b1; bus.alu_result = 32'h99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.state !== 3'(exp_state[i])) begin errors++; $display("FAIL rd0 state[%0d] got %0d want %0d", i, bus.state, exp_state[i]); end
            checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL rd0 we[%0d] got %b want 0", i, bus.we); end
            if (i == 3) begin
                checks++; if (bus.state_regfile_write !== 1'b1 || bus.wdata !== 32'h99) begin errors++; $display("FAIL rd0 wb got rf_write %b wdata %h want 1/99", bus.state_regfile_write, bus.wdata); end
            end
            if (i == 1) bus.run = 1'b0;
        end
    endtask

    // STORE waits 16 MEM cycles; ready in the 16th cycle wins over the timeout.
    task automatic test_timeout_ready_wins();
        int exp;
        bus.run = 1'b1; bus.imem_ready = 1'b1; bus.instr_class = 2'b10;
        bus.instr_wb_en = 1'b0; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            exp = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 3 : (i < 19) ? 4 : 0;
            checks++; if (bus.state !== 3'(exp)) begin errors++; $display("FAIL tmo_ok state[%0d] got %0d want %0d", i, bus.state, exp); end
            if (i == 1) bus.run = 1'b0;
            if (i == 18) bus.dmem_ready = 1'b1;
        end
        checks++; if (bus.timeout_err !== 1'b0 || bus.instr_done !== 1'b1) begin errors++; $display("FAIL tmo_ok err/done got %b/%b want 0/1", bus.timeout_err, bus.instr_done); end
        bus.dmem_ready = 1'b0;
    endtask

    task automatic test_mem_timeout();
        int exp;
        bus.run = 1'b1; bus.imem_ready = 1'b1; bus.instr_class = 2'b10;
        bus.instr_wb_en = 1'b0; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            exp = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 3 : (i < 19) ? 4 : 6;
            checks++; if (bus.state !== 3'(exp)) begin errors++; $display("FAIL tmo state[%0d] got %0d want %0d", i, bus.state, exp); end
            checks++; if (bus.timeout_err !== (i >= 19)) begin errors++; $display("FAIL tmo err[%0d] got %b want %b", i, bus.timeout_err, (i >= 19)); end
            if (i >= 19) begin
                checks++; if (bus.ir_we !== 1'b0 || bus.dmem_req !== 1'b0 || bus.instr_done !== 1'b0) begin errors++; $display("FAIL tmo strobes[%0d] got ir_we %b req %b done %b", i, bus.ir_we, bus.dmem_req, bus.instr_done); end
            end
            if (i == 19) begin bus.run = 1'b1; bus.dmem_ready = 1'b1; end
        end
        bus.dmem_ready = 1'b0;
        do_reset();
        checks++; if (bus.state !== 3'd0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL tmo reset got state %0d err %b want 0/0", bus.state, bus.timeout_err); end
    endtask

    task automatic test_if_timeout();
        bus.run = 1'b1; bus.imem_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            checks++; if (bus.state !== ((i < 16) ? 3'd1 : 3'd6)) begin errors++; $display("FAIL if_tmo state[%0d] got %0d", i, bus.state); end
            checks++; if (bus.timeout_err !== (i >= 16)) begin errors++; $display("FAIL if_tmo err[%0d] got %b", i, bus.timeout_err); end
        end
        do_reset();
    endtask

    task automatic test_reset_mid_wb();
        bus.run = 1'b1; bus.imem_ready = 1'b1; bus.instr_class = 2'b00;
        bus.instr_rd = 5'd9; bus.instr_wb_en = 1'b1; bus.alu_result = 32'h55;
        bus.rdata1 = 32'h77; bus.rdata2 = 32'h66;
        repeat (4) @(negedge clk);
        checks++; if (bus.state !== 3'd5 || bus.we !== 1'b1) begin errors++; $display("FAIL rst_wb pre got state %0d we %b want 5/1", bus.state, bus.we); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.we !== 1'b0 || bus.state !== 3'd0) begin errors++; $display("FAIL rst_wb async got we %b state %0d want 0/0", bus.we, bus.state); end
        checks++; if (bus.state_regfile_write !== 1'b0 || bus.wdata !== 32'h0) begin errors++; $display("FAIL rst_wb write got %b wdata %h want 0/0", bus.state_regfile_write, bus.wdata); end
        checks++; if (bus.opa !== 32'h0 || bus.waddr !== 5'd0) begin errors++; $display("FAIL rst_wb regs got opa %h waddr %0d want 0/0", bus.opa, bus.waddr); end
        @(negedge clk);
        checks++; if (bus.state !== 3'd0 || bus.ir_we !== 1'b0) begin errors++; $display("FAIL rst_wb held got state %0d ir_we %b want 0/0", bus.state, bus.ir_we); end
        bus.run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.state !== 3'd0 || bus.instr_done !== 1'b0) begin errors++; $display("FAIL rst_wb after got state %0d done %b want 0/0", bus.state, bus.instr_done); end
    endtask

    initial begin
        rst = 1'b0;
        bus.run = 1'b0; bus.imem_ready = 1'b0; bus.instr_class = 2'b00;
        bus.instr_wb_en = 1'b0; bus.instr_rd = 5'd0; bus.rdata1 = 32'h0;
        bus.rdata2 = 32'h0; bus.alu_result = 32'h0; bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        test_reset();
        test_alu_branch();
        test_load_operands();
        test_store();
        test_rd_zero();
        test_timeout_ready_wins();
        test_mem_timeout();
        test_if_timeout();
        test_reset_mid_wb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
